// File: rtl/xcv5_rom_fetch.sv
// Tagged byte-address front end for xcv5_bram_rom_32: fixed-latency tag pipeline plus FWFT response FIFO,
// first response LAT+1 cycles after accept; credit-based req_ready; ROM_FETCH_RANGECHK_EN adds range errors.
typedef struct packed {
   logic clk;
   logic clk2x;
} iu_clk_type;

module xcv5_rom_fetch #(
   parameter int ADDRMSB = 10,
   parameter int TIDW    = 5,
   parameter int LAT     = 2,
   parameter int DEPTH   = 8
) (
   input  iu_clk_type          gclk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [31:0]         req_addr,
   input  logic [TIDW-1:0]     req_tid,
   output logic [ADDRMSB:0]    rom_addr,
   input  logic [31:0]         rom_dout,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [31:0]         rsp_data,
   output logic [TIDW-1:0]     rsp_tid,
   output logic                rsp_err,
   output logic                busy
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 2;
   localparam logic [PW-1:0] PTR_ONE = 1;
   localparam logic [PW:0]   CNT_ONE = 1;

   logic clk;
   assign clk = gclk.clk2x;

   logic                accept;
   logic                push;
   logic                pop;
   logic [31:0]         push_dat;
   logic [LAT:1]        pv_vld_q;
   logic [TIDW-1:0]     pv_tid_q [1:LAT];
   logic [PW-1:0]       wr_ptr_q;
   logic [PW-1:0]       rd_ptr_q;
   logic [PW:0]         fifo_cnt_q;
   logic [PW:0]         fifo_cnt_d;
   logic [31:0]         dat_mem_q [DEPTH];
   logic [TIDW-1:0]     tid_mem_q [DEPTH];
   logic [CW-1:0]       inflight;
   logic [CW-1:0]       credit_used;
   logic                unused_bits;

   assign accept   = req_valid && req_ready;
   assign rom_addr = req_addr[ADDRMSB+2:2];

   // Stage 0 is the accept cycle itself; pv_*[k] is the request accepted k edges ago,
   // so pv_vld_q[LAT] lines up with rom_dout.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pv_vld_q <= '0;
      end else begin
         pv_vld_q[1] <= accept;
         for (int i = 2; i <= LAT; i++) begin
            pv_vld_q[i] <= pv_vld_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      pv_tid_q[1] <= req_tid;
      for (int i = 2; i <= LAT; i++) begin
         pv_tid_q[i] <= pv_tid_q[i-1];
      end
   end

`ifdef ROM_FETCH_RANGECHK_EN
   logic [LAT:1] pv_err_q;
   logic         err_mem_q [DEPTH];

   always_ff @(posedge clk) begin
      pv_err_q[1] <= |req_addr[31:ADDRMSB+3];
      for (int i = 2; i <= LAT; i++) begin
         pv_err_q[i] <= pv_err_q[i-1];
      end
      if (push) begin
         err_mem_q[wr_ptr_q] <= pv_err_q[LAT];
      end
   end

   assign push_dat    = pv_err_q[LAT] ? 32'h0 : rom_dout;
   assign rsp_err     = rsp_valid && err_mem_q[rd_ptr_q];
   assign unused_bits = &{1'b0, gclk.clk, req_addr[1:0]};
`else
   assign push_dat    = rom_dout;
   assign rsp_err     = 1'b0;
   assign unused_bits = &{1'b0, gclk.clk, req_addr[1:0], req_addr[31:ADDRMSB+3]};
`endif

   // The ROM cannot stall, so the FIFO write side has no ready; credits keep it from overflowing.
   assign push = pv_vld_q[LAT];
   assign pop  = rsp_valid && rsp_ready;

   always_comb begin
      fifo_cnt_d = fifo_cnt_q;
      if (push && !pop) begin
         fifo_cnt_d = fifo_cnt_q + CNT_ONE;
      end else if (pop && !push) begin
         fifo_cnt_d = fifo_cnt_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         fifo_cnt_q <= fifo_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         dat_mem_q[wr_ptr_q] <= push_dat;
         tid_mem_q[wr_ptr_q] <= pv_tid_q[LAT];
      end
   end

   assign rsp_valid = (fifo_cnt_q != '0);
   assign rsp_data  = dat_mem_q[rd_ptr_q];
   assign rsp_tid   = tid_mem_q[rd_ptr_q];

   // Same-cycle pops are deliberately not credited: keeps rsp_ready off the req_ready path.
   always_comb begin
      inflight = '0;
      for (int i = 1; i <= LAT; i++) begin
         inflight = inflight + CW'(pv_vld_q[i]);
      end
   end

   assign credit_used = inflight + CW'(fifo_cnt_q);
   assign req_ready   = rst && (credit_used < CW'(DEPTH));
   assign busy        = (|pv_vld_q) || rsp_valid;

endmodule
